// File: rtl/debug_uart_pkg.sv
// debug_uart_pkg: shared states, parity codes and frame helper for the debug UART (S_BREAK only with DEBUG_UART_TX_BREAK_EN)
package debug_uart_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
`ifdef DEBUG_UART_TX_BREAK_EN
        , S_BREAK
`endif
    } state_t;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    localparam int IDX_W = 4;

    function automatic int frame_len(input int clks, input int dbits, input int parity, input int stops);
        return (1 + dbits + parity + stops) * clks;
    endfunction

endpackage

// File: rtl/debug_uart_baud_cnt.sv
// debug_uart_baud_cnt: bit-period counter with sync clear and end-of-bit strobe
module debug_uart_baud_cnt #(
    parameter int CLKS_PER_BIT = 87,
    parameter int CNT_W        = 16
) (
    input  logic i_Clock,
    input  logic i_Clear,
    output logic o_Bit_End
);
    logic [CNT_W-1:0] cnt;

    assign o_Bit_End = cnt == CNT_W'(CLKS_PER_BIT - 1);

    // count 0..CLKS_PER_BIT-1 and wrap, held at zero while cleared
    always_ff @(posedge i_Clock)
        cnt <= (i_Clear || o_Bit_End) ? '0 : cnt + 1'b1;

endmodule

// File: rtl/debug_uart_tx_param.sv
// debug_uart_tx_param: parametrised UART transmitter with valid/ready handshake and parity; DEBUG_UART_TX_BREAK_EN adds break generation
module debug_uart_tx_param #(
    parameter int CLKS_PER_BIT = 87,
    parameter int CNT_W        = 16,
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1
) (
    input  logic                 i_Clock,
    input  logic                 i_Reset,
    input  logic                 i_Tx_DV,
    input  logic [DATA_BITS-1:0] i_Tx_Byte,
    input  logic [1:0]           i_Parity_Mode,
`ifdef DEBUG_UART_TX_BREAK_EN
    input  logic                 i_Break,
`endif
    output logic                 o_Tx_Ready,
    output logic                 o_Tx_Serial,
    output logic                 o_Tx_Active,
    output logic                 o_Tx_Done
);
    import debug_uart_pkg::*;

    if (CLKS_PER_BIT < 2 || 64'(CLKS_PER_BIT) >= (64'd1 << CNT_W) ||
        DATA_BITS < 5 || DATA_BITS > 9 || STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_param
        $error("debug_uart_tx_param: illegal parameter set");
    end

    state_t               state, state_d;
    logic [IDX_W-1:0]     idx, idx_d;
    logic [DATA_BITS-1:0] shreg, shreg_d;
    logic [1:0]           mode, mode_d;
    logic                 par, par_d, serial_d;
    logic                 bit_end, accept, last_data, last_stop, par_en, brk_req;

`ifdef DEBUG_UART_TX_BREAK_EN
    logic brk_min;
    assign brk_req = i_Break;
    assign brk_min = idx == IDX_W'(DATA_BITS + 2) || (bit_end && idx == IDX_W'(DATA_BITS + 1));
`else
    assign brk_req = 1'b0;
`endif

    debug_uart_baud_cnt #(.CLKS_PER_BIT(CLKS_PER_BIT), .CNT_W(CNT_W)) u_baud (
        .i_Clock  (i_Clock),
        .i_Clear  (i_Reset || state == S_IDLE),
        .o_Bit_End(bit_end)
    );

    assign o_Tx_Ready  = state == S_IDLE && !brk_req;
    assign o_Tx_Active = state inside {S_START, S_DATA, S_PARITY, S_STOP};
    assign accept      = i_Tx_DV && o_Tx_Ready;
    assign last_data   = idx == IDX_W'(DATA_BITS - 1);
    assign last_stop   = idx == IDX_W'(STOP_BITS - 1);
    assign par_en      = mode == PAR_EVEN || mode == PAR_ODD;
    assign o_Tx_Done   = state == S_STOP && bit_end && last_stop && !i_Reset;

    // next state, bit index, shift register and the line level for the next cycle
    always_comb begin
        state_d = state;
        idx_d   = idx;
        shreg_d = shreg;
        mode_d  = mode;
        par_d   = par;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_START;
                    shreg_d = i_Tx_Byte;
                    mode_d  = i_Parity_Mode;
                    par_d   = ^i_Tx_Byte ^ (i_Parity_Mode == PAR_ODD);
                end
`ifdef DEBUG_UART_TX_BREAK_EN
                else if (brk_req) state_d = S_BREAK;
`endif
            end
            S_START: state_d = bit_end ? S_DATA : S_START;
            S_DATA: if (bit_end) begin
                shreg_d = shreg >> 1;
                idx_d   = last_data ? '0 : idx + 1'b1;
                state_d = !last_data ? S_DATA : par_en ? S_PARITY : S_STOP;
            end
            S_PARITY: state_d = bit_end ? S_STOP : S_PARITY;
            S_STOP: if (bit_end) begin
                idx_d   = last_stop ? '0 : idx + 1'b1;
                state_d = last_stop ? S_IDLE : S_STOP;
            end
`ifdef DEBUG_UART_TX_BREAK_EN
            S_BREAK: begin
                if (bit_end && idx != IDX_W'(DATA_BITS + 2)) idx_d = idx + 1'b1;
                if (brk_min && !brk_req) begin
                    state_d = S_IDLE;
                    idx_d   = '0;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
        serial_d = (state_d == S_DATA)   ? shreg_d[0] :
                   (state_d == S_PARITY) ? par :
                   (state_d inside {S_IDLE, S_STOP});
    end

    // state and frame registers; the line is registered so it leads the state by nothing
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state       <= S_IDLE;
            idx         <= '0;
            shreg       <= '0;
            mode        <= PAR_NONE;
            par         <= 1'b0;
            o_Tx_Serial <= 1'b1;
        end else begin
            state       <= state_d;
            idx         <= idx_d;
            shreg       <= shreg_d;
            mode        <= mode_d;
            par         <= par_d;
            o_Tx_Serial <= serial_d;
        end
    end

endmodule

// File: tb/tb_debug_uart_tx_param.sv
// tb_debug_uart_tx_param: scoreboard bench for debug_uart_tx_param (8N1 and 7-bit/2-stop instances, break test with DEBUG_UART_TX_BREAK_EN)
module tb_debug_uart_tx_param;

    localparam int CPB = 4;

    typedef struct {
        logic        inst;
        logic [63:0] wave;
        int          len;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] dv;
    logic [7:0] tb_byte;
    logic [1:0] pm;
    logic       gap_chk;
    wire  [1:0] rdy, ser, act, dn;
`ifdef DEBUG_UART_TX_BREAK_EN
    logic       brk;
`endif

    exp_t exp_q[$];
    int   acc_q[$];
    int   cyc = 0;
    int   stray = 0;
    int   n_chk = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    debug_uart_tx_param #(.CLKS_PER_BIT(CPB), .CNT_W(16), .DATA_BITS(8), .STOP_BITS(1)) u_dut_a (
        .i_Clock      (clk),
        .i_Reset      (rst),
        .i_Tx_DV      (dv[0]),
        .i_Tx_Byte    (tb_byte),
        .i_Parity_Mode(pm),
`ifdef DEBUG_UART_TX_BREAK_EN
        .i_Break      (brk),
`endif
        .o_Tx_Ready   (rdy[0]),
        .o_Tx_Serial  (ser[0]),
        .o_Tx_Active  (act[0]),
        .o_Tx_Done    (dn[0])
    );

    debug_uart_tx_param #(.CLKS_PER_BIT(CPB), .CNT_W(16), .DATA_BITS(7), .STOP_BITS(2)) u_dut_b (
        .i_Clock      (clk),
        .i_Reset      (rst),
        .i_Tx_DV      (dv[1]),
        .i_Tx_Byte    (tb_byte[6:0]),
        .i_Parity_Mode(pm),
`ifdef DEBUG_UART_TX_BREAK_EN
        .i_Break      (1'b0),
`endif
        .o_Tx_Ready   (rdy[1]),
        .o_Tx_Serial  (ser[1]),
        .o_Tx_Active  (act[1]),
        .o_Tx_Done    (dn[1])
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h required %0h", tag, got, want);
    endtask

    // expected line waveform: start, data LSB first, optional parity, stop bits, each CPB cycles
    function automatic exp_t mk_exp(input logic sel, input logic [7:0] d, input logic [1:0] m);
        exp_t e;
        logic [15:0] bits;
        logic p, b;
        int n, nb, sb;
        nb = sel ? 7 : 8;
        sb = sel ? 2 : 1;
        bits = '0;
        p = 1'b0;
        n = 1;
        for (int j = 0; j < nb; j++) begin
            b = 1'(d >> j);
            p = p ^ b;
            bits = bits | (16'(b) << n);
            n++;
        end
        if (m == 2'b01 || m == 2'b10) begin
            bits = bits | (16'((m == 2'b10) ? !p : p) << n);
            n++;
        end
        for (int j = 0; j < sb; j++) begin
            bits = bits | (16'd1 << n);
            n++;
        end
        e.inst = sel;
        e.len = n * CPB;
        e.wave = '0;
        for (int j = 0; j < e.len; j++) e.wave = e.wave | (64'(1'(bits >> (j / CPB))) << j);
        return e;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_mon
        int          fcnt, idle, t0;
        logic [63:0] wave;
        logic        ok;
        exp_t        e;

        initial forever begin
            @(posedge clk);
            if (!rst && dv[g] && rdy[g]) acc_q.push_back(cyc);
        end

        initial begin
            fcnt = 0;
            idle = 0;
            wave = '0;
            forever begin
                @(negedge clk);
                if (rst) begin
                    fcnt = 0;
                    idle = 0;
                end else if (act[g]) begin
                    if (fcnt == 0) begin
                        wave = '0;
                        if (gap_chk) check("b2b_gap", 64'(idle), 64'd1);
                    end
                    wave = wave | (64'(ser[g]) << fcnt);
                    fcnt++;
                    if (dn[g]) begin
                        ok = exp_q.size() != 0 && acc_q.size() != 0;
                        check("sb_nonempty", 64'(ok), 64'd1);
                        if (ok) begin
                            e = exp_q.pop_front();
                            t0 = acc_q.pop_front();
                            check("inst", 64'(g), 64'(e.inst));
                            check("active_len", 64'(fcnt), 64'(e.len));
                            check("done_latency", 64'(cyc - t0), 64'(e.len));
                            check("wave", wave, e.wave);
                        end
                        fcnt = 0;
                        idle = 0;
                    end
                end else begin
                    idle++;
                    if (dn[g]) stray++;
                end
            end
        end
    end

    task automatic send(input logic sel, input logic [7:0] d, input logic [1:0] m);
        int k;
        for (k = 0; k < 400 && !rdy[sel]; k++) @(negedge clk);
        if (!rdy[sel]) begin
            check("ready_timeout", 64'(rdy[sel]), 64'd1);
            return;
        end
        tb_byte = d;
        pm = m;
        dv[sel] = 1'b1;
        exp_q.push_back(mk_exp(sel, d, m));
        @(negedge clk);
        dv[sel] = 1'b0;
        tb_byte = 8'($urandom);
        pm = 2'($urandom);
    endtask

    task automatic wait_idle(input logic sel);
        int k;
        for (k = 0; k < 1000; k++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !act[sel]) break;
        end
        if (k == 1000) check("frame_timeout", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;
        rst = 1'b1;
        dv = '0;
        tb_byte = '0;
        pm = '0;
        gap_chk = 1'b0;
`ifdef DEBUG_UART_TX_BREAK_EN
        brk = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check("reset_a", 64'({ser[0], rdy[0], act[0], dn[0]}), 64'hC);
        check("reset_b", 64'({ser[1], rdy[1], act[1], dn[1]}), 64'hC);
        rst = 1'b0;
        @(negedge clk);

        send(1'b0, 8'hA5, 2'b00);
        wait_idle(1'b0);
        send(1'b0, 8'h07, 2'b01);
        wait_idle(1'b0);
        send(1'b0, 8'h07, 2'b10);
        wait_idle(1'b0);
        send(1'b1, 8'h55, 2'b00);
        wait_idle(1'b1);
        send(1'b0, 8'h5A, 2'b11);
        wait_idle(1'b0);

        tb_byte = 8'h01;
        pm = 2'b00;
        dv[0] = 1'b1;
        exp_q.push_back(mk_exp(1'b0, 8'h01, 2'b00));
        @(negedge clk);
        tb_byte = 8'hFE;
        exp_q.push_back(mk_exp(1'b0, 8'hFE, 2'b00));
        @(negedge clk);
        gap_chk = 1'b1;
        for (k = 0; k < 200 && act[0]; k++) @(negedge clk);
        @(negedge clk);
        dv[0] = 1'b0;
        @(negedge clk);
        gap_chk = 1'b0;
        wait_idle(1'b0);

        send(1'b0, 8'hC3, 2'b00);
        repeat (17) @(negedge clk);
        check("data_bit3", 64'(ser[0]), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        check("reset_mid_frame", 64'({ser[0], act[0], dn[0]}), 64'h4);
        rst = 1'b0;
        exp_q.delete();
        acc_q.delete();
        @(negedge clk);
        check("ready_after_reset", 64'({rdy[0], act[0], dn[0]}), 64'h4);
        send(1'b0, 8'h3C, 2'b00);
        wait_idle(1'b0);

`ifdef DEBUG_UART_TX_BREAK_EN
        brk = 1'b1;
        k = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (c == 0) check("break_ready_low", 64'(rdy[0]), 64'd0);
            if (c == 5) brk = 1'b0;
            if (ser[0]) break;
            k++;
        end
        check("break_len", 64'(k), 64'd40);
        check("break_ready_back", 64'(rdy[0]), 64'd1);
        send(1'b0, 8'h96, 2'b01);
        wait_idle(1'b0);
`endif

        repeat (5) @(negedge clk);
        check("stray_done", 64'(stray), 64'd0);
        check("exp_left", 64'(exp_q.size()), 64'd0);
        check("acc_left", 64'(acc_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
